// File: rtl/ks8_mpadd_seq.sv
// Multi-precision add/subtract sequencer: one 8-bit Kogge-Stone adder walked
// across the operands LSB byte first, carry registered between bytes.
module ks8_mpadd_seq #(
    parameter int WORDS = 4
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 in_valid,
    output logic                 in_ready,
    input  logic [8*WORDS-1:0]   in_a,
    input  logic [8*WORDS-1:0]   in_b,
    input  logic                 in_sub,
    output logic                 out_valid,
    input  logic                 out_ready,
    output logic [8*WORDS-1:0]   out_sum,
    output logic                 out_cout,
    output logic                 out_ovf,
    output logic                 busy
);
    localparam int W  = 8 * WORDS;
    localparam int IW = $clog2(WORDS);

    // Handshakes: a transfer happens on a rising edge where valid & ready are
    // both high; valid never waits on ready, and ready here is purely state-based.
    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t        state_q, state_d;
    logic [IW-1:0] idx_q, idx_d;
    logic          c_q, c_d;
    logic [W-1:0]  opa_q, opa_d;
    logic [W-1:0]  opb_q, opb_d;
    logic [W-1:0]  sum_q, sum_d;
    logic          cout_q, cout_d;
    logic          ovf_q, ovf_d;
    logic          last;

    logic [7:0] ks_x1, ks_x2, ks_s;
    logic       ks_cin, ks_cout;
    logic [7:0] ks_p, ks_p1, ks_p2;
    logic [7:0] ks_g0, ks_g1, ks_g2, ks_g3;

    assign last   = (idx_q == IW'(WORDS - 1));
    assign ks_cin = c_q;

    always_comb begin
        ks_x1 = 8'h00;
        ks_x2 = 8'h00;
        for (int i = 0; i < WORDS; i++) begin
            if (idx_q == IW'(i)) begin
                ks_x1 = opa_q[8*i +: 8];
                ks_x2 = opb_q[8*i +: 8];
            end
        end
    end

    // ks8: carry-in folded into bit 0 generate, then three prefix levels (1, 2, 4).
    always_comb begin
        ks_p    = ks_x1 ^ ks_x2;
        ks_g0   = (ks_x1 & ks_x2) | {7'b0, ks_p[0] & ks_cin};
        ks_g1   = ks_g0 | (ks_p & {ks_g0[6:0], 1'b0});
        ks_p1   = ks_p & {ks_p[6:0], 1'b1};
        ks_g2   = ks_g1 | (ks_p1 & {ks_g1[5:0], 2'b00});
        ks_p2   = ks_p1 & {ks_p1[5:0], 2'b11};
        ks_g3   = ks_g2 | (ks_p2 & {ks_g2[3:0], 4'h0});
        ks_s    = ks_p ^ {ks_g3[6:0], ks_cin};
        ks_cout = ks_g3[7];
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (in_valid)  state_d = RUN;
            RUN:     if (last)      state_d = DONE;
            DONE:    if (out_ready) state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        in_ready  = 1'b0;
        out_valid = 1'b0;
        busy      = 1'b0;
        case (state_q)
            IDLE: in_ready = 1'b1;
            RUN:  busy = 1'b1;
            DONE: begin
                out_valid = 1'b1;
                busy      = 1'b1;
            end
            default: ;
        endcase
    end

    // Subtract is A + ~B + 1: invert B once at accept and seed the carry with 1.
    always_comb begin
        opa_d  = opa_q;
        opb_d  = opb_q;
        c_d    = c_q;
        idx_d  = idx_q;
        sum_d  = sum_q;
        cout_d = cout_q;
        ovf_d  = ovf_q;
        if (state_q == IDLE && in_valid) begin
            opa_d = in_a;
            opb_d = in_sub ? ~in_b : in_b;
            c_d   = in_sub;
            idx_d = '0;
        end else if (state_q == RUN) begin
            for (int i = 0; i < WORDS; i++) begin
                if (idx_q == IW'(i)) begin
                    sum_d[8*i +: 8] = ks_s;
                end
            end
            c_d   = ks_cout;
            idx_d = idx_q + 1'b1;
            if (last) begin
                cout_d = ks_cout;
                ovf_d  = opa_q[W-1] ^ opb_q[W-1] ^ ks_s[7] ^ ks_cout;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            opa_q  <= '0;
            opb_q  <= '0;
            c_q    <= 1'b0;
            idx_q  <= '0;
            sum_q  <= '0;
            cout_q <= 1'b0;
            ovf_q  <= 1'b0;
        end else begin
            opa_q  <= opa_d;
            opb_q  <= opb_d;
            c_q    <= c_d;
            idx_q  <= idx_d;
            sum_q  <= sum_d;
            cout_q <= cout_d;
            ovf_q  <= ovf_d;
        end
    end

    assign out_sum  = sum_q;
    assign out_cout = cout_q;
    assign out_ovf  = ovf_q;

endmodule

// File: tb/tb_ks8_mpadd_seq.sv
// Bench for ks8_mpadd_seq: directed corner cases on a WORDS=4 instance plus
// randomized traffic on WORDS=4, 2 and 8 instances against an arithmetic model.
module tb_ks8_mpadd_seq;
    localparam int W     = 32;
    localparam int N_RND = 1000;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic          rst_n;
    logic          in_valid, in_ready, in_sub;
    logic          out_valid, out_ready, out_cout, out_ovf, busy;
    logic [W-1:0]  in_a, in_b, out_sum;
    logic [65:0]   exp_q[$];
    logic          prod_done;
    int            total = 0;
    int            bad   = 0;

    ks8_mpadd_seq #(.WORDS(4)) u_dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_a      (in_a),
        .in_b      (in_b),
        .in_sub    (in_sub),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_sum   (out_sum),
        .out_cout  (out_cout),
        .out_ovf   (out_ovf),
        .busy      (busy)
    );

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic check1(input string name, input logic act, input logic exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0b expected %0b", name, act, exp);
        end
    endtask

    function automatic logic [65:0] mk(input logic ovf, input logic cout, input logic [63:0] sum);
        return {ovf, cout, sum};
    endfunction

    // Reference: plain w-bit arithmetic; carry = unsigned carry out (no-borrow
    // for subtract), overflow from operand/result signs.
    function automatic logic [65:0] model(input int w, input logic [63:0] a_in,
                                          input logic [63:0] b_in, input logic sub);
        logic [63:0] mask, a, b, s;
        logic [64:0] full;
        logic        c, sa, sb, ss, v;
        mask = (w == 64) ? '1 : ((64'd1 << w) - 64'd1);
        a = a_in & mask;
        b = b_in & mask;
        if (sub) begin
            s = (a - b) & mask;
            c = (a >= b);
        end else begin
            full = {1'b0, a} + {1'b0, b};
            s    = full[63:0] & mask;
            c    = full[w];
        end
        sa = a[w-1];
        sb = b[w-1];
        ss = s[w-1];
        v  = sub ? ((sa != sb) && (ss != sa)) : ((sa == sb) && (ss != sa));
        return {v, c, s};
    endfunction

    always @(negedge clk) begin : main_mon
        logic [65:0] e;
        if (rst_n && out_valid && out_ready) begin
            if (exp_q.size() == 0) begin
                total++;
                bad++;
                $display("FAIL main_unexpected: got sum 0x%0h expected no result", out_sum);
            end else begin
                e = exp_q.pop_front();
                check("main_sum", 64'(out_sum), e[63:0]);
                check1("main_cout", out_cout, e[64]);
                check1("main_ovf", out_ovf, e[65]);
            end
        end
    end

    task automatic issue(input logic [31:0] a, input logic [31:0] b, input logic sub,
                         input logic [65:0] exp);
        int n;
        in_a     = a;
        in_b     = b;
        in_sub   = sub;
        in_valid = 1'b1;
        n = 0;
        @(negedge clk);
        while (!in_ready && n < 100) begin
            @(negedge clk);
            n++;
        end
        if (!in_ready) begin
            total++;
            bad++;
            $display("FAIL main_accept_timeout: in_ready=%0b expected 1", in_ready);
            in_valid = 1'b0;
        end else begin
            @(posedge clk);
            exp_q.push_back(exp);
            #1;
            in_valid = 1'b0;
            in_a     = $urandom();
            in_b     = $urandom();
            in_sub   = 1'($urandom_range(0, 1));
        end
    endtask

    task automatic drain();
        int n;
        n = 0;
        while (exp_q.size() != 0 && n < 300) begin
            @(negedge clk);
            n++;
        end
        if (exp_q.size() != 0) begin
            total++;
            bad++;
            $display("FAIL main_drain_timeout: pending=%0d expected 0", exp_q.size());
            exp_q.delete();
        end
        @(posedge clk);
        #1;
    endtask

    for (genvar g = 0; g < 2; g++) begin : g_rnd
        localparam int GW = (g == 0) ? 2 : 8;
        localparam int GB = 8 * GW;
        logic          r_rst_n, r_in_valid, r_in_ready, r_in_sub;
        logic          r_out_valid, r_out_ready, r_out_cout, r_out_ovf, r_busy;
        logic [GB-1:0] r_in_a, r_in_b, r_out_sum;
        logic [65:0]   r_exp_q[$];
        int            r_got = 0;
        logic          done;

        ks8_mpadd_seq #(.WORDS(GW)) u_dut (
            .clk       (clk),
            .rst_n     (r_rst_n),
            .in_valid  (r_in_valid),
            .in_ready  (r_in_ready),
            .in_a      (r_in_a),
            .in_b      (r_in_b),
            .in_sub    (r_in_sub),
            .out_valid (r_out_valid),
            .out_ready (r_out_ready),
            .out_sum   (r_out_sum),
            .out_cout  (r_out_cout),
            .out_ovf   (r_out_ovf),
            .busy      (r_busy)
        );

        initial begin : drv
            logic [63:0] a, b;
            logic        s;
            int          n;
            done       = 1'b0;
            r_rst_n    = 1'b0;
            r_in_valid = 1'b0;
            r_in_a     = '0;
            r_in_b     = '0;
            r_in_sub   = 1'b0;
            repeat (3) @(posedge clk);
            #1 r_rst_n = 1'b1;
            for (int i = 0; i < N_RND; i++) begin
                repeat ($urandom_range(0, 2)) begin
                    @(posedge clk);
                    #1;
                end
                a = {$urandom(), $urandom()};
                b = {$urandom(), $urandom()};
                s = 1'($urandom_range(0, 1));
                case ($urandom_range(0, 7))
                    0: a = '1;
                    1: b = '1;
                    2: a = 64'd1 << (GB - 1);
                    3: b = 64'd1 << (GB - 1);
                    default: ;
                endcase
                r_in_a     = a[GB-1:0];
                r_in_b     = b[GB-1:0];
                r_in_sub   = s;
                r_in_valid = 1'b1;
                n = 0;
                @(negedge clk);
                while (!r_in_ready && n < 100) begin
                    @(negedge clk);
                    n++;
                end
                if (!r_in_ready) begin
                    total++;
                    bad++;
                    $display("FAIL rnd%0d_accept_timeout: in_ready=%0b expected 1", GW, r_in_ready);
                    r_in_valid = 1'b0;
                end else begin
                    @(posedge clk);
                    r_exp_q.push_back(model(GB, a, b, s));
                    #1 r_in_valid = 1'b0;
                end
            end
            n = 0;
            while (r_exp_q.size() != 0 && n < 500) begin
                @(negedge clk);
                n++;
            end
            @(posedge clk);
            check($sformatf("rnd%0d_count", GW), 64'(r_got), 64'(N_RND));
            done = 1'b1;
        end

        initial begin : cons
            r_out_ready = 1'b0;
            forever begin
                @(posedge clk);
                #1 r_out_ready = ($urandom_range(0, 3) != 0);
            end
        end

        always @(negedge clk) begin : mon
            logic [65:0] e;
            if (r_rst_n && r_out_valid && r_out_ready) begin
                if (r_exp_q.size() == 0) begin
                    total++;
                    bad++;
                    $display("FAIL rnd%0d_unexpected: got sum 0x%0h expected no result", GW, r_out_sum);
                end else begin
                    e = r_exp_q.pop_front();
                    r_got++;
                    check($sformatf("rnd%0d_sum", GW), 64'(r_out_sum), e[63:0]);
                    check1($sformatf("rnd%0d_cout", GW), r_out_cout, e[64]);
                    check1($sformatf("rnd%0d_ovf", GW), r_out_ovf, e[65]);
                end
            end
        end
    end

    initial begin : main_seq
        logic [31:0] ra, rb;
        logic        rs;
        int          n;
        rst_n     = 1'b0;
        in_valid  = 1'b0;
        in_a      = '0;
        in_b      = '0;
        in_sub    = 1'b0;
        out_ready = 1'b0;
        prod_done = 1'b0;

        // reset state
        #12;
        check1("rst_in_ready", in_ready, 1'b1);
        check1("rst_out_valid", out_valid, 1'b0);
        check1("rst_busy", busy, 1'b0);
        check("rst_out_sum", 64'(out_sum), 64'h0);
        check1("rst_out_cout", out_cout, 1'b0);
        check1("rst_out_ovf", out_ovf, 1'b0);
        @(posedge clk);
        #1 rst_n = 1'b1;
        @(posedge clk);
        #1;

        // carry out of every byte, exact latency
        out_ready = 1'b1;
        issue(32'hFFFF_FFFF, 32'h0000_0001, 1'b0, mk(1'b0, 1'b1, 64'h0));
        @(negedge clk);
        check1("t1_busy_run", busy, 1'b1);
        check1("t1_in_ready_run", in_ready, 1'b0);
        repeat (3) @(negedge clk);
        check1("t1_valid_early", out_valid, 1'b0);
        @(negedge clk);
        check1("t1_valid_latency", out_valid, 1'b1);
        @(negedge clk);
        check1("t1_in_ready_back", in_ready, 1'b1);
        check1("t1_valid_drop", out_valid, 1'b0);
        @(posedge clk);
        #1;

        // signed overflow, subtract with and without borrow
        issue(32'h7FFF_FFFF, 32'h0000_0001, 1'b0, mk(1'b1, 1'b0, 64'h8000_0000));
        drain();
        issue(32'h0000_0005, 32'h0000_0007, 1'b1, mk(1'b0, 1'b0, 64'hFFFF_FFFE));
        drain();
        issue(32'h8000_0000, 32'h0000_0001, 1'b1, mk(1'b1, 1'b1, 64'h7FFF_FFFF));
        drain();

        // backpressure with input noise
        out_ready = 1'b0;
        issue(32'h89AB_CDEF, 32'h7654_3210, 1'b0, mk(1'b0, 1'b0, 64'hFFFF_FFFF));
        n = 0;
        @(negedge clk);
        while (!out_valid && n < 20) begin
            @(negedge clk);
            n++;
        end
        check1("t4_valid_rise", out_valid, 1'b1);
        for (int k = 0; k < 5; k++) begin
            @(posedge clk);
            #1;
            in_valid = 1'b1;
            in_a     = $urandom();
            in_b     = $urandom();
            in_sub   = 1'($urandom_range(0, 1));
            @(negedge clk);
            check1("t4_hold_valid", out_valid, 1'b1);
            check1("t4_hold_in_ready", in_ready, 1'b0);
            check("t4_hold_sum", 64'(out_sum), 64'hFFFF_FFFF);
            check1("t4_hold_cout", out_cout, 1'b0);
            check1("t4_hold_ovf", out_ovf, 1'b0);
        end
        @(posedge clk);
        #1;
        in_valid  = 1'b0;
        out_ready = 1'b1;
        @(negedge clk);
        @(negedge clk);
        check1("t4_idle_ready", in_ready, 1'b1);
        check1("t4_no_accept", busy, 1'b0);
        @(posedge clk);
        #1;

        // reset in the middle of RUN
        issue(32'hDEAD_BEEF, 32'h0102_0304, 1'b0, mk(1'b0, 1'b0, 64'h0));
        @(posedge clk);
        @(posedge clk);
        #1 rst_n = 1'b0;
        exp_q.delete();
        #1;
        check1("t5_in_ready", in_ready, 1'b1);
        check1("t5_out_valid", out_valid, 1'b0);
        check1("t5_busy", busy, 1'b0);
        check("t5_out_sum", 64'(out_sum), 64'h0);
        check1("t5_out_cout", out_cout, 1'b0);
        check1("t5_out_ovf", out_ovf, 1'b0);
        @(posedge clk);
        #1 rst_n = 1'b1;
        @(posedge clk);
        #1;
        issue(32'h1234_5678, 32'h1111_1111, 1'b0, mk(1'b0, 1'b0, 64'h2345_6789));
        drain();

        // random traffic with stalls on both sides
        fork
            begin
                for (int i = 0; i < 300; i++) begin
                    repeat ($urandom_range(0, 2)) begin
                        @(posedge clk);
                        #1;
                    end
                    ra = $urandom();
                    rb = $urandom();
                    rs = 1'($urandom_range(0, 1));
                    issue(ra, rb, rs, model(32, 64'(ra), 64'(rb), rs));
                end
                prod_done = 1'b1;
            end
            begin
                while (!prod_done) begin
                    @(posedge clk);
                    #1 out_ready = ($urandom_range(0, 3) != 0);
                end
            end
        join
        out_ready = 1'b1;
        drain();

        n = 0;
        while (!(g_rnd[0].done && g_rnd[1].done) && n < 60000) begin
            @(posedge clk);
            n++;
        end
        if (!(g_rnd[0].done && g_rnd[1].done)) begin
            total++;
            bad++;
            $display("FAIL rnd_timeout: done=%0b%0b expected 11", g_rnd[0].done, g_rnd[1].done);
        end
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/ks8_mpadd_seq.md
Name: ks8_mpadd_seq

Overview:
Multi-precision add/subtract sequencer built around one instance of the team's 8-bit prefix adder (ks8). It accepts two operands of 8*WORDS bits over a valid/ready handshake. It then runs the 8-bit adder across the operands one byte per cycle, LSB byte first, with the carry registered between bytes, and returns the full-width result on a valid/ready handshake. It is the area-saving alternative to a full-width prefix adder for wide, latency-tolerant arithmetic.

Parameters:
WORDS, 4, number of 8-bit slices per operand; operand width W = 8*WORDS; legal range 2..16.

Ports:
clk  input  1  rising-edge clock
rst_n  input  1  asynchronous active-low reset
in_valid  input  1  operand request valid
in_ready  output  1  block can accept an operation
in_a  input  W  operand A (unsigned or two's complement)
in_b  input  W  operand B
in_sub  input  1  1 = compute A-B, 0 = compute A+B
out_valid  output  1  result valid
out_ready  input  1  consumer accepts result
out_sum  output  W  result, A+B or A-B modulo 2^W
out_cout  output  1  carry out of MSB; for subtract, 1 = no borrow
out_ovf  output  1  signed two's-complement overflow
busy  output  1  high in RUN or DONE

Behaviour:
- Clock and reset: single clock `clk`. Reset `rst_n` is asynchronous and active-low.
- Reset values: state = IDLE; in_ready = 1; out_valid = 0; out_sum = 0; out_cout = 0; out_ovf = 0; busy = 0. The byte index, carry register and operand registers are also cleared.
- FSM states: IDLE, RUN, DONE.
- IDLE:
  - in_ready = 1.
  - On in_valid & in_ready at a clock edge:
    - Latch opA = in_a.
    - Latch opB = in_sub ? ~in_b : in_b.
    - Carry register c = in_sub.
    - idx = 0; go to RUN.
  - in_a, in_b and in_sub are sampled only at that edge. Later changes are ignored.
- RUN:
  - in_ready = 0.
  - Each cycle, ks8 is driven as follows:
    - x1 = opA byte[idx]
    - x2 = opB byte[idx]
    - cin = c
  - At the edge:
    - Result byte[idx] <= s.
    - c <= cout.
    - idx <= idx+1.
  - When idx == WORDS-1 at the edge:
    - Register out_cout <= cout.
    - Register out_ovf <= opA[W-1] ^ opB[W-1] ^ s[7] ^ cout. This equals carry-in XOR carry-out of the MSB, using the inverted B for subtract.
    - Go to DONE.
- DONE:
  - out_valid = 1.
  - out_sum, out_cout and out_ovf are held stable until out_valid & out_ready at an edge, then the FSM returns to IDLE.
  - in_ready = 0 throughout DONE. A new request is accepted no earlier than the cycle after the result handshake.
- Latency and throughput:
  - Accept at edge T gives out_valid = 1 after edge T+WORDS.
  - Minimum issue interval is WORDS+2 cycles when out_ready is held high.
- Intermediate result bytes may change on out_sum during RUN. out_sum is defined only while out_valid = 1.
- Other rules:
  - ks8 is the only adder. No full-width adders are permitted.
  - idx width is clog2(WORDS). No wrap-around occurs because RUN exits at WORDS-1.
  - in_valid without in_ready is held by the producer. The block never drops or duplicates an operation.
  - out_ready while out_valid = 0 has no effect.
- Reset mid-operation: an assertion of rst_n in RUN or DONE aborts immediately. All outputs go to reset values and the operation is lost.
- No simultaneous accept and complete is possible, because the states are exclusive.

Test Plan:
1. WORDS=4, A=0xFFFFFFFF, B=0x00000001, sub=0, out_ready=1 -> out_valid exactly 4 edges after accept; out_sum=0x00000000, out_cout=1, out_ovf=0; in_ready back to 1 one cycle after the result handshake.
2. A=0x7FFFFFFF, B=0x00000001, sub=0 -> out_sum=0x80000000, out_cout=0, out_ovf=1 (carry ripples through all four bytes).
3. A=0x00000005, B=0x00000007, sub=1 -> out_sum=0xFFFFFFFE, out_cout=0 (borrow), out_ovf=0. Also A=0x80000000, B=0x00000001, sub=1 -> out_sum=0x7FFFFFFF, out_cout=1, out_ovf=1.
4. Backpressure: hold out_ready=0 for 5 cycles after out_valid rises, and change in_a/in_b/in_valid during those cycles -> out_sum/out_cout/out_ovf stable, in_ready=0, nothing accepted; returns to IDLE on the first edge with out_ready=1.
5. Reset mid-run: assert rst_n=0 two cycles after accept -> immediately in_ready=1, out_valid=0, busy=0, all outputs 0. After release, A=0x12345678, B=0x11111111 -> out_sum=0x23456789, with no leakage from the aborted operation.
6. Back-to-back random: 1000 random A/B/sub with random in_valid/out_ready stalls, WORDS=2 and WORDS=8 -> every result matches the reference model (sum mod 2^W, carry, signed overflow), in order, with no drops or duplicates.
